minv_host_ctrl: RTL and testbench



---
 rtl/minv_host_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_minv_host_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/minv_host_ctrl.sv
// ---------------------------------------------------------------------------
// minv_host_ctrl
//
// Host-side sequencer for a serial 256-bit modular-inverse unit.  One run:
//   IDLE --cmd_start--> LOAD_A (16 words of a) --> LOAD_P (16 words of p)
//   --> START (one-cycle minv_en) --> WAIT (for minv_rdy, with timeout)
//   --> READ (16 result words out, LSW first) --> FIN (done pulse) --> IDLE
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   cmd_start    start request, honoured only in IDLE
//   in_valid/in_data/in_ready       operand stream (a then p, LSW first)
//   out_valid/out_data/out_last/out_ready  result stream (LSW first)
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a run completes
//   err          set by a WAIT timeout, cleared by the next accepted start
//   datain/loada/loadp/minv_en/outx1/outx2  serial port of the inverse unit
//   regx1out/regx2out/minv_rdy/minv_flag   results and status of the unit
// ---------------------------------------------------------------------------

// Protocol invariants of the controller's strobes, kept apart from the RTL.
module minv_host_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic in_ready,
    input logic loada,
    input logic loadp,
    input logic minv_en,
    input logic outx1,
    input logic outx2,
    input logic out_valid,
    input logic out_last
);

    // Sample the invariants once per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert ($onehot0({loada, loadp, minv_en, outx1, outx2}))
                else $error("minv_host_ctrl_chk: more than one unit strobe active");
            assert (!(loada || loadp) || in_ready)
                else $error("minv_host_ctrl_chk: load strobe without in_ready");
            assert (!out_last || out_valid)
                else $error("minv_host_ctrl_chk: out_last without out_valid");
        end else begin
            assert (!(in_ready || loada || loadp || minv_en || outx1 || outx2))
                else $error("minv_host_ctrl_chk: strobe active during reset");
        end
    end

endmodule

module minv_host_ctrl #(
    parameter int TIMEOUT_CYC = 65535,
    parameter int WORDS       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] datain,
    output logic        loada,
    output logic        loadp,
    output logic        minv_en,
    output logic        outx1,
    output logic        outx2,
    input  logic [15:0] regx1out,
    input  logic [15:0] regx2out,
    input  logic        minv_rdy,
    input  logic        minv_flag
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_P = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_READ   = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;

    // WAIT counter wide enough to hold 0 .. TIMEOUT_CYC-1.
    localparam int             TCW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCW-1:0] TC_LAST    = TCW'(TIMEOUT_CYC - 1);
    // rdy may still be high from the previous run for the first two cycles.
    localparam logic [TCW-1:0] BLANK_CYC  = TCW'(2);
    localparam logic [3:0]     WCNT_LAST  = 4'(WORDS - 1);
    localparam logic [4:0]     RD_WORDS   = 5'(WORDS);

    logic [2:0]     state_q,     state_d;
    logic [3:0]     wcnt_q,      wcnt_d;
    logic [4:0]     rcnt_q,      rcnt_d;
    logic [TCW-1:0] wait_cnt_q,  wait_cnt_d;
    logic           sel_q,       sel_d;
    logic [15:0]    out_data_q,  out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           err_q,       err_d;

    logic           in_ready_s;
    logic           loada_s;
    logic           loadp_s;
    logic           minv_en_s;
    logic           outx1_s;
    logic           outx2_s;
    logic           done_s;
    logic           rd_strobe_s;
    logic           out_last_s;

    // The held word is the last one once all 16 have been captured.
    assign out_last_s = out_valid_q & (rcnt_q == RD_WORDS);

    // Next-state and strobe decode for the run sequencer.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        wait_cnt_d  = wait_cnt_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        in_ready_s  = 1'b0;
        loada_s     = 1'b0;
        loadp_s     = 1'b0;
        minv_en_s   = 1'b0;
        outx1_s     = 1'b0;
        outx2_s     = 1'b0;
        done_s      = 1'b0;
        rd_strobe_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_d = ST_LOAD_A;
                    wcnt_d  = 4'd0;
                    rcnt_d  = 5'd0;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD_A: begin
                in_ready_s = 1'b1;
                loada_s    = in_valid;
                if (in_valid) begin
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d = ST_LOAD_P;
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end

            ST_LOAD_P: begin
                in_ready_s = 1'b1;
                loadp_s    = in_valid;
                if (in_valid) begin
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_LOAD_P;
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end

            ST_START: begin
                minv_en_s  = 1'b1;
                wait_cnt_d = {TCW{1'b0}};
                state_d    = ST_WAIT;
            end

            ST_WAIT: begin
                // A ready seen after blanking wins over a timeout in the same cycle.
                if ((wait_cnt_q >= BLANK_CYC) && minv_rdy) begin
                    state_d = ST_READ;
                    sel_d   = minv_flag;
                    rcnt_d  = 5'd0;
                end else if (wait_cnt_q == TC_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + TCW'(1);
                end
            end

            ST_READ: begin
                // Fetch a new word only when the output slot is free or draining.
                rd_strobe_s = (~out_valid_q | out_ready) & (rcnt_q < RD_WORDS);
                outx1_s     = rd_strobe_s & ~sel_q;
                outx2_s     = rd_strobe_s & sel_q;
                if (rd_strobe_s) begin
                    out_data_d  = sel_q ? regx2out : regx1out;
                    out_valid_d = 1'b1;
                    rcnt_d      = rcnt_q + 5'd1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
                if (out_valid_q & out_ready & out_last_s) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_READ;
                end
            end

            ST_FIN: begin
                done_s  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 4'd0;
            rcnt_q      <= 5'd0;
            wait_cnt_q  <= {TCW{1'b0}};
            sel_q       <= 1'b0;
            out_data_q  <= 16'd0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wait_cnt_q  <= wait_cnt_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // Strobes are forced low while reset is asserted so an abort issues
    // nothing further, even in the cycle before the reset edge.
    assign in_ready  = rst & in_ready_s;
    assign loada     = rst & loada_s;
    assign loadp     = rst & loadp_s;
    assign minv_en   = rst & minv_en_s;
    assign outx1     = rst & outx1_s;
    assign outx2     = rst & outx2_s;
    assign datain    = (rst & in_ready_s) ? in_data : 16'd0;
    assign busy      = rst & (state_q != ST_IDLE);
    assign done      = rst & done_s;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_s;

    minv_host_ctrl_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready),
        .loada     (loada),
        .loadp     (loadp),
        .minv_en   (minv_en),
        .outx1     (outx1),
        .outx2     (outx2),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_minv_host_ctrl.sv
module tb_minv_host_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy, done, err;
    logic [15:0] datain;
    logic        loada, loadp, minv_en, outx1, outx2;
    logic [15:0] regx1out, regx2out;
    logic        minv_rdy, minv_flag;

    always #5 clk = ~clk;

    minv_host_ctrl #(.TIMEOUT_CYC(20), .WORDS(16)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err),
        .datain(datain), .loada(loada), .loadp(loadp), .minv_en(minv_en),
        .outx1(outx1), .outx2(outx2),
        .regx1out(regx1out), .regx2out(regx2out), .minv_rdy(minv_rdy), .minv_flag(minv_flag)
    );

    // ---------------- inverse-unit behavioural model ----------------
    logic [255:0] res1_v = '0, res2_v = '0;
    int  cfg_d = 3;
    bit  cfg_stale = 1'b0, cfg_never = 1'b0, cfg_flag = 1'b0;
    int  k = 0, idx1 = 0, idx2 = 0;
    bit  running = 1'b0;

    always @(posedge clk) begin
        if (minv_en) begin
            running <= 1'b1;
            k       <= 1;
            idx1    <= 0;
            idx2    <= 0;
        end else begin
            if (running && k < 100000) k <= k + 1;
            if (outx1) idx1 <= idx1 + 1;
            if (outx2) idx2 <= idx2 + 1;
        end
    end

    // k cycles after minv_en: cycles 1,2 show the stale level, then rdy rises at cfg_d.
    assign minv_rdy  = !running ? 1'b0 : (k <= 2) ? cfg_stale : (!cfg_never && k >= cfg_d);
    assign minv_flag = cfg_flag;
    assign regx1out  = res1_v[(idx1 & 15) * 16 +: 16];
    assign regx2out  = res2_v[(idx2 & 15) * 16 +: 16];

    // ---------------- monitor ----------------
    int cyc = 0, n_loada = 0, n_loadp = 0, n_en = 0, n_x1 = 0, n_x2 = 0, n_done = 0, n_bad = 0;
    int en_cyc = -1, x_cyc = -1, err_cyc = -1;
    logic [15:0] a_got[$], p_got[$], o_got[$];
    bit          l_got[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst && cmd_start && !busy) begin
            n_loada <= 0; n_loadp <= 0; n_en <= 0; n_x1 <= 0; n_x2 <= 0;
            n_done <= 0; n_bad <= 0; en_cyc <= -1; x_cyc <= -1; err_cyc <= -1;
            a_got.delete(); p_got.delete(); o_got.delete(); l_got.delete();
        end else begin
            if (loada) begin n_loada <= n_loada + 1; a_got.push_back(datain); end
            if (loadp) begin n_loadp <= n_loadp + 1; p_got.push_back(datain); end
            if (minv_en) begin n_en <= n_en + 1; en_cyc <= cyc; end
            if (outx1) n_x1 <= n_x1 + 1;
            if (outx2) n_x2 <= n_x2 + 1;
            if ((outx1 || outx2) && x_cyc < 0) x_cyc <= cyc;
            if (done) n_done <= n_done + 1;
            if (err && err_cyc < 0) err_cyc <= cyc;
            if (out_valid && out_ready) begin o_got.push_back(out_data); l_got.push_back(out_last); end
            if ($countones({loada, loadp, minv_en, outx1, outx2}) > 1 ||
                ((loada || loadp) && !in_ready) || (in_ready && datain !== in_data))
                n_bad <= n_bad + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference inverse by exhaustive search over the residues.
    function automatic logic [255:0] modinv_small(input int a, input int p);
        for (int x = 1; x < p; x++) if (((a * x) % p) == 1) return 256'(x);
        return 256'd0;
    endfunction

    function automatic logic [255:0] pack16(input logic [15:0] q[$]);
        logic [255:0] v = '0;
        for (int i = 0; i < q.size() && i < 16; i++) v[i*16 +: 16] = q[i];
        return v;
    endfunction

    // Start a run and stream up to nmax operand words (a then p).
    task automatic load_ops(input logic [255:0] a, input logic [255:0] p,
                            input bit gaps, input bit hold, input int nmax);
        logic [511:0] ops;
        int i = 0, guard = 0;
        ops = {p, a};
        cmd_start = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;   // not consumed in IDLE
        @(posedge clk); #1;
        cmd_start = hold;
        while (i < nmax && guard < 600) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = in_valid ? ops[i*16 +: 16] : 16'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        cmd_start = 1'b0; in_valid = 1'b0;
        check("load_budget", 256'(i), 256'(nmax));
    endtask

    task automatic wait_end(input int rmode);
        int  n = 0;
        bit  fin = 1'b0;
        while (!fin && n < 1500) begin
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ($urandom_range(0, 3) == 0);
            endcase
            @(negedge clk);
            if (done || err) fin = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        check("run_ends", 256'(fin), 256'd1);
    endtask

    task automatic do_run(input string tag, input logic [255:0] a, input logic [255:0] p,
                          input logic [255:0] r1, input logic [255:0] r2,
                          input bit flag, input bit stale, input bit never, input int d,
                          input int rmode, input bit gaps, input bit hold);
        logic [15:0] lv;
        cfg_flag = flag; cfg_stale = stale; cfg_never = never; cfg_d = d;
        res1_v = r1; res2_v = r2;
        load_ops(a, p, gaps, hold, 32);
        wait_end(rmode);
        check({tag, ".a_cnt"}, 256'(a_got.size()), 256'd16);
        check({tag, ".a_val"}, pack16(a_got), a);
        check({tag, ".p_cnt"}, 256'(p_got.size()), 256'd16);
        check({tag, ".p_val"}, pack16(p_got), p);
        check({tag, ".en_cnt"}, 256'(n_en), 256'd1);
        check({tag, ".strobe_rules"}, 256'(n_bad), 256'd0);
        check({tag, ".busy_end"}, 256'(busy), 256'd0);
        if (never) begin
            check({tag, ".err"}, 256'(err), 256'd1);
            check({tag, ".no_done"}, 256'(n_done), 256'd0);
            check({tag, ".no_outx"}, 256'(n_x1 + n_x2), 256'd0);
            check({tag, ".err_lat"}, 256'(err_cyc - en_cyc), 256'd21);
        end else begin
            lv = '0;
            for (int i = 0; i < l_got.size() && i < 16; i++) lv[i] = l_got[i];
            check({tag, ".err"}, 256'(err), 256'd0);
            check({tag, ".done_cnt"}, 256'(n_done), 256'd1);
            check({tag, ".outx1_cnt"}, 256'(n_x1), flag ? 256'd0 : 256'd16);
            check({tag, ".outx2_cnt"}, 256'(n_x2), flag ? 256'd16 : 256'd0);
            check({tag, ".out_cnt"}, 256'(o_got.size()), 256'd16);
            check({tag, ".out_val"}, pack16(o_got), flag ? r2 : r1);
            check({tag, ".out_last"}, 256'(lv), 256'h8000);
            check({tag, ".rdy_lat"}, 256'(x_cyc - en_cyc), 256'(d + 1));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit leak;
        rst = 1'b0; cmd_start = 1'b1; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_strobes", 256'({in_ready, loada, loadp, minv_en, outx1, outx2}), 256'd0);
        check("reset_status", 256'({busy, done, err, out_valid, out_last}), 256'd0);
        check("reset_data", 256'({out_data, datain}), 256'd0);
        @(posedge clk); #1;
        cmd_start = 1'b0; in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;

        do_run("nominal", 256'd3, 256'd7, modinv_small(3, 7), rand256(), 1'b0, 1'b0, 1'b0, 5, 0, 1'b0, 1'b0);
        do_run("flag_x2", rand256(), rand256(), rand256(), rand256(), 1'b1, 1'b1, 1'b0, 3, 0, 1'b0, 1'b0);
        do_run("ready_toggle", rand256(), rand256(), rand256(), rand256(), 1'b0, 1'b1, 1'b0, 4, 1, 1'b1, 1'b0);
        do_run("stale_rdy", rand256(), rand256(), rand256(), rand256(), 1'b0, 1'b1, 1'b0, 3, 2, 1'b0, 1'b0);
        do_run("cmd_held", rand256(), rand256(), rand256(), rand256(), 1'b1, 1'b0, 1'b0, 6, 1, 1'b1, 1'b1);
        do_run("timeout", rand256(), rand256(), rand256(), rand256(), 1'b0, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0);
        do_run("after_timeout", rand256(), rand256(), rand256(), rand256(), 1'b1, 1'b0, 1'b0, 4, 1, 1'b0, 1'b0);

        // Abort after the 7th p word, with in_valid still asserted.
        cfg_never = 1'b0;
        load_ops(rand256(), rand256(), 1'b0, 1'b0, 23);
        in_valid = 1'b1; in_data = 16'hBEEF; rst = 1'b0;
        @(negedge clk);
        check("abort_strobes_now", 256'({in_ready, loada, loadp, minv_en, outx1, outx2}), 256'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_all_zero", 256'({in_ready, loada, loadp, minv_en, outx1, outx2, busy, done,
                                      err, out_valid, out_last, out_data, datain}), 256'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        leak = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (in_ready || loada || loadp || busy) leak = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("abort_stays_idle", 256'(leak), 256'd0);
        do_run("after_abort", rand256(), rand256(), rand256(), rand256(), 1'b0, 1'b0, 1'b0, 3, 0, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++)
            do_run("random", rand256(), rand256(), rand256(), rand256(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0, $urandom_range(3, 12), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
